// File: rtl/ysyx_bus_arb.sv
// rtl/ysyx_bus_arb.sv - single-port memory arbiter for fetch, load and store requesters
// Optional YSYX_BUS_ARB_RR_EN: round-robin between fetch and LSU instead of fixed LSU priority.
module ysyx_bus_arb #(
    parameter int BIT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BIT_W-1:0] ifu_araddr,
    input  logic             ifu_arvalid,
    output logic [BIT_W-1:0] ifu_rdata,
    output logic             ifu_rvalid,
    input  logic [BIT_W-1:0] lsu_araddr,
    input  logic             lsu_arvalid,
    input  logic [7:0]       lsu_rstrb,
    output logic [BIT_W-1:0] lsu_rdata,
    output logic             lsu_rvalid,
    input  logic [BIT_W-1:0] lsu_awaddr,
    input  logic             lsu_awvalid,
    input  logic [BIT_W-1:0] lsu_wdata,
    input  logic [7:0]       lsu_wstrb,
    input  logic             lsu_wvalid,
    output logic             lsu_wready,
    output logic [BIT_W-1:0] mem_addr,
    output logic             mem_we,
    output logic [BIT_W-1:0] mem_wdata,
    output logic [7:0]       mem_strb,
    output logic             mem_valid,
    input  logic             mem_ready,
    input  logic [BIT_W-1:0] mem_rdata,
    input  logic             mem_resp_valid
);

    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] IFU_REQ     = 3'd1;
    localparam logic [2:0] IFU_WAIT    = 3'd2;
    localparam logic [2:0] LSU_RD_REQ  = 3'd3;
    localparam logic [2:0] LSU_RD_WAIT = 3'd4;
    localparam logic [2:0] LSU_WR_REQ  = 3'd5;
    localparam logic [2:0] LSU_WR_WAIT = 3'd6;

    logic [2:0]       state;
    logic [BIT_W-1:0] req_addr;
    logic [BIT_W-1:0] req_wdata;
    logic [7:0]       req_strb;
    logic             req_we;
    logic             gap;

    logic store_pend;
    logic lsu_pend;
    logic pick_lsu;
    logic grant_ifu;
    logic grant_store;
    logic grant_load;
    logic in_req;

    assign store_pend = lsu_awvalid & lsu_wvalid;
    assign lsu_pend   = store_pend | lsu_arvalid;

`ifdef YSYX_BUS_ARB_RR_EN
    // rr_ptr=1 means the fetch side wins the next contested grant
    logic rr_ptr;
    assign pick_lsu = lsu_pend & (~ifu_arvalid | ~rr_ptr);
`else
    assign pick_lsu = lsu_pend;
`endif

    assign grant_ifu   = ifu_arvalid & ~pick_lsu;
    assign grant_store = pick_lsu & store_pend;
    assign grant_load  = pick_lsu & ~store_pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            req_addr  <= '0;
            req_wdata <= '0;
            req_strb  <= '0;
            req_we    <= 1'b0;
            gap       <= 1'b0;
`ifdef YSYX_BUS_ARB_RR_EN
            rr_ptr    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // the cycle after a completion is skipped so the served master can drop its valid
                    if (gap) begin
                        gap <= 1'b0;
                    end else if (grant_ifu | pick_lsu) begin
`ifdef YSYX_BUS_ARB_RR_EN
                        rr_ptr <= pick_lsu;
`endif
                        if (grant_store) begin
                            state     <= LSU_WR_REQ;
                            req_addr  <= lsu_awaddr;
                            req_wdata <= lsu_wdata;
                            req_strb  <= lsu_wstrb;
                            req_we    <= 1'b1;
                        end else if (grant_load) begin
                            state     <= LSU_RD_REQ;
                            req_addr  <= lsu_araddr;
                            req_wdata <= '0;
                            req_strb  <= lsu_rstrb;
                            req_we    <= 1'b0;
                        end else begin
                            state     <= IFU_REQ;
                            req_addr  <= ifu_araddr;
                            req_wdata <= '0;
                            req_strb  <= 8'hf;
                            req_we    <= 1'b0;
                        end
                    end
                end
                IFU_REQ:     if (mem_ready) state <= IFU_WAIT;
                LSU_RD_REQ:  if (mem_ready) state <= LSU_RD_WAIT;
                LSU_WR_REQ:  if (mem_ready) state <= LSU_WR_WAIT;
                IFU_WAIT, LSU_RD_WAIT, LSU_WR_WAIT: begin
                    if (mem_resp_valid) begin
                        state <= IDLE;
                        gap   <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_req = (state == IFU_REQ) | (state == LSU_RD_REQ) | (state == LSU_WR_REQ);

    assign mem_valid = in_req;
    assign mem_addr  = in_req ? req_addr  : '0;
    assign mem_wdata = in_req ? req_wdata : '0;
    assign mem_strb  = in_req ? req_strb  : 8'h0;
    assign mem_we    = in_req & req_we;

    assign ifu_rvalid = (state == IFU_WAIT) & mem_resp_valid;
    assign lsu_rvalid = (state == LSU_RD_WAIT) & mem_resp_valid;
    assign lsu_wready = (state == LSU_WR_WAIT) & mem_resp_valid;
    assign ifu_rdata  = ifu_rvalid ? mem_rdata : '0;
    assign lsu_rdata  = lsu_rvalid ? mem_rdata : '0;

endmodule

// File: doc/ysyx_bus_arb.md
YSYX_BUS_ARB -- requirements
Module: ysyx_bus_arb

Interface
REQ-001 SHALL have parameter BIT_W, default 32, meaning address/data width.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports ifu_araddr input BIT_W, ifu_arvalid input 1  fetch read request, level held until ifu_rvalid.
REQ-005 SHALL have ports ifu_rdata output BIT_W, ifu_rvalid output 1  fetch read response, one-cycle pulse.
REQ-006 SHALL have ports lsu_araddr input BIT_W, lsu_arvalid input 1, lsu_rstrb input 8  load request, held until lsu_rvalid.
REQ-007 SHALL have ports lsu_rdata output BIT_W, lsu_rvalid output 1  load response, one-cycle pulse.
REQ-008 SHALL have ports lsu_awaddr input BIT_W, lsu_awvalid input 1, lsu_wdata input BIT_W, lsu_wstrb input 8, lsu_wvalid input 1  store request, held until lsu_wready.
REQ-009 SHALL have port lsu_wready  output 1  store completion, one-cycle pulse.
REQ-010 SHALL have ports mem_addr output BIT_W, mem_we output 1, mem_wdata output BIT_W, mem_strb output 8, mem_valid output 1  downstream request.
REQ-011 SHALL have port mem_ready  input 1  downstream accepts request when high with mem_valid.
REQ-012 SHALL have ports mem_rdata input BIT_W, mem_resp_valid input 1  downstream response (read data or write ack).

Function
REQ-013 SHALL implement states IDLE, IFU_REQ, IFU_WAIT, LSU_RD_REQ, LSU_RD_WAIT, LSU_WR_REQ, LSU_WR_WAIT.
REQ-014 SHALL, in IDLE, treat LSU store pending as lsu_awvalid & lsu_wvalid, LSU load as lsu_arvalid, fetch as ifu_arvalid.
REQ-015 SHALL, when LSU store and load both pending, serve the store first.
REQ-016 SHALL, in IDLE with a winner, latch addr/wdata/strb/we into request registers and enter the matching *_REQ state at that edge.
REQ-017 SHALL drive mem_valid=1 and mem_addr/mem_we/mem_wdata/mem_strb from request registers only in *_REQ states; mem_valid asserts first in the cycle after the IDLE grant.
REQ-018 SHALL drive mem_strb from lsu_rstrb for loads, lsu_wstrb for stores, 8'hf for fetches; mem_we=1 only for stores; mem_wdata=0 for reads.
REQ-019 SHALL move *_REQ -> *_WAIT on the edge where mem_ready=1; hold *_REQ and all mem_* outputs stable otherwise.
REQ-020 SHALL, in *_WAIT with mem_resp_valid=1, pulse the owner's response combinationally that cycle (ifu_rvalid/lsu_rvalid with rdata=mem_rdata, or lsu_wready) and return to IDLE at that edge.
REQ-021 SHALL hold ifu_rdata/lsu_rdata at 0 whenever the matching rvalid is 0; non-owners never see a response.
REQ-022 SHALL ignore mem_resp_valid outside *_WAIT states.
REQ-023 SHALL, in the first IDLE cycle after any completion, grant nothing (one-cycle gap so the served requester drops valid); grants resume next cycle.
REQ-024 SHALL ignore requester address/data changes after grant; latched values used until completion.
REQ-025 SHALL serve one transaction at a time; no outstanding-request overlap.

Reset
REQ-026 SHALL, on rst assertion at any time including mid-transaction, asynchronously enter IDLE, clear request registers, gap flag, and priority pointer.
REQ-027 SHALL hold all outputs 0 during and immediately after reset.
REQ-028 SHALL drop an in-flight transaction on reset without emitting a response.

Configuration
REQ-029 SHALL, with YSYX_BUS_ARB_RR_EN defined, arbitrate fetch vs LSU round-robin: 1-bit pointer, reset favouring LSU, flips to the other class after each grant.
REQ-030 SHALL, without YSYX_BUS_ARB_RR_EN, use fixed priority LSU over IFU; no pointer state.

Verification
REQ-031 Fetch only: ifu_arvalid, addr 0x80000000, mem_ready same cycle as mem_valid, resp 2 cycles later rdata 0x00000413 -> mem_valid one cycle after request, ifu_rvalid=1 with ifu_rdata=0x00000413 for exactly one cycle.
REQ-032 Store: awaddr 0x80001004, wdata 0xdeadbeef, wstrb 0x3, mem_ready held 0 for 3 cycles -> mem_* stable 4 cycles, mem_we=1, mem_strb=0x3, lsu_wready single pulse on ack.
REQ-033 Simultaneous ifu_arvalid and lsu_arvalid from reset -> LSU granted first in both builds; with RR_EN IFU next, then LSU; without, LSU every time while pending.
REQ-034 Load with lsu_rstrb=0x1 while lsu_awvalid&lsu_wvalid also high -> store issued first, load second with mem_strb=0x1.
REQ-035 rst pulse during IFU_WAIT, then mem_resp_valid=1 -> no ifu_rvalid, state IDLE, all outputs 0.
REQ-036 Requester keeps valid high one cycle after response -> no duplicate grant in the gap cycle.
